// File: rtl/mux_serial_logic_unit_pkg.sv
// mslu_pkg: shared types for the bit-serial mux logic unit.
//   op_e    : opcode encoding presented on the op port
//   state_e : controller state encoding
//   PARITY_EN : 1 when built with MSLU_PARITY_EN (parity port, flop and
//               second mux cell present), 0 otherwise
package mslu_pkg;

    typedef enum logic [2:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_NOT  = 3'd4,
        OP_XOR  = 3'd5,
        OP_XNOR = 3'd6,
        OP_RSVD = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

`ifdef MSLU_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

endpackage

// File: rtl/mux_serial_logic_unit_if.sv
// Handshake bundle of the bit-serial mux logic unit.
//   in_valid/in_ready/op/a/b : operand side (source -> unit)
//   out_valid/out_ready/result/err[/parity] : result side (unit -> consumer)
// parity exists only when MSLU_PARITY_EN is defined.
// master = operand source and result consumer; slave = the unit.
interface mux_serial_logic_unit_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             err;

`ifdef MSLU_PARITY_EN
    logic             parity;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, err, parity
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, err, parity
    );
`else
    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result, err
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result, err
    );
`endif

endinterface

// File: rtl/mux_serial_logic_unit_cell.sv
// mslu_mux_cell: single 2:1 mux, the only logic element that computes
// result bits (and parity bits when enabled).
//   i0 : selected when s = 0
//   i1 : selected when s = 1
//   s  : select
//   y  : output
module mslu_mux_cell (
    input  logic i0,
    input  logic i1,
    input  logic s,
    output logic y
);

    assign y = (~s & i0) | (s & i1);

endmodule

// File: rtl/mux_serial_logic_unit.sv
// mux_serial_logic_unit: bit-serial bitwise logic unit. Operands A and B are
// evaluated one bit per clock, LSB first, through a single 2:1 mux cell whose
// data inputs are chosen from {0, 1, b, ~b} by the opcode and whose select is
// the current A bit.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of mux_serial_logic_unit_if (operand and result handshakes)
// Build option MSLU_PARITY_EN adds a running parity flop, a second mux cell
// and the parity output.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | in_ready=1, waiting for operands
// ST_SHIFT | evaluating one bit per cycle, counter = bit index
// ST_DONE  | first cycle loads result port; then out_valid=1 until taken
module mux_serial_logic_unit
    import mslu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mux_serial_logic_unit_if.slave bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_e           state_q,     state_d;
    logic [CW-1:0]    cnt_q,       cnt_d;
    op_e              op_q,        op_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] res_sh_q,    res_sh_d;
    logic [WIDTH-1:0] result_q,    result_d;
    logic             err_q,       err_d;
    logic             out_valid_q, out_valid_d;

    logic cell_i0;
    logic cell_i1;
    logic cell_y;

`ifdef MSLU_PARITY_EN
    logic par_q, par_d;
    logic par_y;
`endif

    // Opcode -> mux data inputs, using the current B bit.
    always_comb begin
        cell_i0 = 1'b0;
        cell_i1 = 1'b0;
        case (op_q)
            OP_AND:  begin cell_i0 = 1'b0;       cell_i1 = b_sh_q[0];  end
            OP_OR:   begin cell_i0 = b_sh_q[0];  cell_i1 = 1'b1;       end
            OP_NAND: begin cell_i0 = 1'b1;       cell_i1 = ~b_sh_q[0]; end
            OP_NOR:  begin cell_i0 = ~b_sh_q[0]; cell_i1 = 1'b0;       end
            OP_NOT:  begin cell_i0 = 1'b1;       cell_i1 = 1'b0;       end
            OP_XOR:  begin cell_i0 = b_sh_q[0];  cell_i1 = ~b_sh_q[0]; end
            OP_XNOR: begin cell_i0 = ~b_sh_q[0]; cell_i1 = b_sh_q[0];  end
            default: begin cell_i0 = 1'b0;       cell_i1 = 1'b0;       end
        endcase
    end

    mslu_mux_cell u_data_cell (
        .i0 (cell_i0),
        .i1 (cell_i1),
        .s  (a_sh_q[0]),
        .y  (cell_y)
    );

`ifdef MSLU_PARITY_EN
    // Parity toggles whenever the freshly computed bit is 1.
    mslu_mux_cell u_parity_cell (
        .i0 (par_q),
        .i1 (~par_q),
        .s  (cell_y),
        .y  (par_y)
    );
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_sh_d    = res_sh_q;
        result_d    = result_q;
        err_d       = err_q;
        out_valid_d = out_valid_q;
`ifdef MSLU_PARITY_EN
        par_d       = par_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d   = bus.a;
                    b_sh_d   = bus.b;
                    op_d     = op_e'(bus.op);
                    cnt_d    = '0;
                    res_sh_d = '0;
                    err_d    = (bus.op == OP_RSVD);
`ifdef MSLU_PARITY_EN
                    par_d    = 1'b0;
`endif
                    // Reserved opcode skips evaluation and reports 0 with err.
                    state_d  = (bus.op == OP_RSVD) ? ST_DONE : ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                res_sh_d = {cell_y, res_sh_q[WIDTH-1:1]};
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
`ifdef MSLU_PARITY_EN
                par_d    = par_y;
`endif
                if (cnt_q == LAST_BIT) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_DONE: begin
                // The result port only changes here, so it holds its last
                // value through the next transaction's SHIFT phase.
                if (!out_valid_q) begin
                    result_d    = res_sh_q;
                    out_valid_d = 1'b1;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end

            default: begin
                state_d     = ST_IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_AND;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_sh_q    <= '0;
            result_q    <= '0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_sh_q    <= res_sh_d;
            result_q    <= result_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MSLU_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign bus.parity = par_q;
`endif

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mux_serial_logic_unit.sv
module tb_mux_serial_logic_unit;
    import mslu_pkg::*;

    localparam int W = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_serial_logic_unit_if #(.WIDTH(W)) bus ();

    mux_serial_logic_unit #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain bitwise operators, no bit-serial detail.
    function automatic logic [W-1:0] model_res(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            0: return a & b;
            1: return a | b;
            2: return ~(a & b);
            3: return ~(a | b);
            4: return ~a;
            5: return a ^ b;
            6: return ~(a ^ b);
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input int op);
        return (op == 7) ? 1 : W + 1;
    endfunction

    // Drives one transaction; returns what was observed. Inputs change #1
    // after the rising edge, outputs are sampled at the same point.
    task automatic run_txn(input int op, input logic [W-1:0] a, input logic [W-1:0] b, input int hold,
                           output logic [W-1:0] res, output logic err_v, output logic par_v,
                           output int lat, output int busy, output bit stable, output bit timeout);
        int k;
        int held;
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 50) begin
            @(posedge clk); #1; k++;
        end
        timeout = (k >= 50);
        res = '0; err_v = 1'b0; par_v = 1'b0; lat = 0; busy = 0; stable = 1'b1; held = 0;
        bus.in_valid  = 1'b1;
        bus.op        = op[2:0];
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = (hold == 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.op       = 3'($urandom);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        k = 0;
        while (bus.in_ready !== 1'b1 && k < 200) begin
            busy++;
            if (bus.out_valid === 1'b1) begin
                if (lat == 0) begin
                    lat   = k;
                    res   = bus.result;
                    err_v = bus.err;
`ifdef MSLU_PARITY_EN
                    par_v = bus.parity;
`endif
                end else if (bus.result !== res || bus.err !== err_v) begin
                    stable = 1'b0;
                end
                if (held >= hold) bus.out_ready = 1'b1;
                else held++;
            end else if (lat != 0) begin
                stable = 1'b0;
            end
            @(posedge clk); #1; k++;
        end
        bus.out_ready = 1'b0;
        if (k >= 200) timeout = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.op = '0; bus.a = '0; bus.b = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.result !== '0 || bus.err !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: in_ready=%b out_valid=%b result=%h err=%b, need 1 0 00 0",
                     bus.in_ready, bus.out_valid, bus.result, bus.err);
        end
`ifdef MSLU_PARITY_EN
        checks++;
        if (bus.parity !== 1'b0) begin
            errors++;
            $display("FAIL reset_parity: got %b need 0", bus.parity);
        end
`endif
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: in_ready=%b out_valid=%b, need 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_and();
        logic [W-1:0] r; logic e, p; int lat, busy; bit st, to;
        run_txn(0, 8'hF0, 8'h3C, 0, r, e, p, lat, busy, st, to);
        checks++;
        if (to || r !== 8'h30 || e !== 1'b0) begin
            errors++;
            $display("FAIL and_result: got %h err=%b to=%b, need 30 err=0", r, e, to);
        end
        checks++;
        if (lat != W + 1) begin
            errors++;
            $display("FAIL and_latency: got %0d need %0d", lat, W + 1);
        end
        checks++;
        if (busy != W + 2) begin
            errors++;
            $display("FAIL and_busy: got %0d need %0d", busy, W + 2);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] r1, r2; logic e1, e2, p; int l1, l2, b1, b2; bit s1, s2, t1, t2;
        run_txn(5, 8'hAA, 8'hFF, 0, r1, e1, p, l1, b1, s1, t1);
        run_txn(6, 8'hAA, 8'hFF, 0, r2, e2, p, l2, b2, s2, t2);
        checks++;
        if (t1 || r1 !== 8'h55 || e1 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_xor: got %h err=%b, need 55 err=0", r1, e1);
        end
        checks++;
        if (t2 || r2 !== 8'hAA || e2 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_xnor: got %h err=%b, need aa err=0", r2, e2);
        end
        checks++;
        if (b1 != 10 || b2 != 10) begin
            errors++;
            $display("FAIL b2b_busy: got %0d,%0d need 10,10", b1, b2);
        end
    endtask

    task automatic test_not();
        logic [W-1:0] r; logic e, p; int lat, busy; bit st, to;
        run_txn(4, 8'h0F, W'($urandom), 0, r, e, p, lat, busy, st, to);
        checks++;
        if (to || r !== 8'hF0 || e !== 1'b0) begin
            errors++;
            $display("FAIL not_result: got %h err=%b, need f0 err=0", r, e);
        end
    endtask

    task automatic test_hold();
        logic [W-1:0] r; logic e, p; int lat, busy; bit st, to;
        run_txn(3, 8'h00, 8'h01, 5, r, e, p, lat, busy, st, to);
        checks++;
        if (to || r !== 8'hFE) begin
            errors++;
            $display("FAIL hold_result: got %h need fe", r);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL hold_stable: outputs changed while out_ready low (got 0 need 1)");
        end
        checks++;
        if (busy != W + 2 + 5) begin
            errors++;
            $display("FAIL hold_busy: got %0d need %0d", busy, W + 7);
        end
`ifdef MSLU_PARITY_EN
        checks++;
        if (p !== 1'b1) begin
            errors++;
            $display("FAIL hold_parity: got %b need 1", p);
        end
`endif
    endtask

    task automatic test_reserved();
        logic [W-1:0] r; logic e, p; int lat, busy; bit st, to;
        run_txn(7, 8'hFF, 8'h00, 0, r, e, p, lat, busy, st, to);
        checks++;
        if (to || r !== 8'h00 || e !== 1'b1 || lat != 1) begin
            errors++;
            $display("FAIL rsvd: got result=%h err=%b lat=%0d, need 00 1 1", r, e, lat);
        end
`ifdef MSLU_PARITY_EN
        checks++;
        if (p !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_parity: got %b need 0", p);
        end
`endif
        run_txn(1, 8'h0F, 8'hF0, 0, r, e, p, lat, busy, st, to);
        checks++;
        if (to || r !== 8'hFF || e !== 1'b0) begin
            errors++;
            $display("FAIL rsvd_then_or: got %h err=%b, need ff err=0", r, e);
        end
    endtask

    task automatic test_reset_abort();
        logic [W-1:0] r; logic e, p; int lat, busy; bit st, to;
        bus.in_valid = 1'b1; bus.op = 3'd0; bus.a = 8'h5A; bus.b = 8'hFF; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2; rst = 1'b1; #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.result !== '0) begin
            errors++;
            $display("FAIL async_reset: out_valid=%b in_ready=%b result=%h, need 0 1 00",
                     bus.out_valid, bus.in_ready, bus.result);
        end
        @(negedge clk); rst = 1'b0; bus.out_ready = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.result !== '0) begin
                errors++;
                $display("FAIL stale_after_reset: out_valid=%b result=%h, need 0 00", bus.out_valid, bus.result);
            end
        end
        run_txn(0, 8'hFF, 8'h81, 0, r, e, p, lat, busy, st, to);
        checks++;
        if (to || r !== 8'h81 || e !== 1'b0) begin
            errors++;
            $display("FAIL after_reset_and: got %h err=%b, need 81 err=0", r, e);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] r, ea, eb, exp; logic e, p; int lat, busy, op, hold; bit st, to;
        for (int i = 0; i < 40; i++) begin
            op   = int'($urandom_range(0, 7));
            hold = int'($urandom_range(0, 3));
            ea   = W'($urandom);
            eb   = W'($urandom);
            exp  = model_res(op, ea, eb);
            run_txn(op, ea, eb, hold, r, e, p, lat, busy, st, to);
            checks++;
            if (to || r !== exp || e !== (op == 7)) begin
                errors++;
                $display("FAIL rand_result[%0d] op=%0d: got %h err=%b, need %h err=%b", i, op, r, e, exp, op == 7);
            end
            checks++;
            if (lat != model_lat(op) || busy != model_lat(op) + 1 + hold || !st) begin
                errors++;
                $display("FAIL rand_timing[%0d] op=%0d: lat=%0d busy=%0d stable=%b, need %0d %0d 1",
                         i, op, lat, busy, st, model_lat(op), model_lat(op) + 1 + hold);
            end
`ifdef MSLU_PARITY_EN
            checks++;
            if (p !== ^exp) begin
                errors++;
                $display("FAIL rand_parity[%0d]: got %b need %b", i, p, ^exp);
            end
`endif
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_and();
        test_back_to_back();
        test_not();
        test_hold();
        test_reserved();
        test_reset_abort();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
